// File: rtl/rr_slice_arbiter.sv
// Round-robin arbiter with a bounded time slice per owner.
// Every release or slice expiry is followed by one idle cycle before the next grant.
module rr_slice_arbiter #(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int SLICE = 8,
    parameter int SW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [W-1:0]  grant_idx,
    output logic          busy,
    output logic          preempt,
    output logic [SW-1:0] slice_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [W-1:0]  ptr, ptr_n;
    logic [N-1:0]  grant_n;
    logic [W-1:0]  grant_idx_n;
    logic          busy_n;
    logic          preempt_n;
    logic [SW-1:0] slice_cnt_n;

    logic          found;
    logic [W-1:0]  pick;
    logic [W-1:0]  next_owner;
    int            cand;

    // Circular search for the first requester at or after the pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = W'(cand);
            end
        end
    end

    assign next_owner = (grant_idx == W'(N - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        grant_n     = grant;
        grant_idx_n = grant_idx;
        busy_n      = busy;
        preempt_n   = 1'b0;
        slice_cnt_n = slice_cnt;
        case (state)
            IDLE: begin
                grant_n     = '0;
                grant_idx_n = '0;
                busy_n      = 1'b0;
                slice_cnt_n = '0;
                if (found) begin
                    state_n        = GRANT;
                    grant_n[pick]  = 1'b1;
                    grant_idx_n    = pick;
                    busy_n         = 1'b1;
                end
            end
            GRANT: begin
                // A dropped request outranks slice expiry, so no preempt pulse then.
                if (!req[grant_idx] || slice_cnt == SW'(SLICE - 1)) begin
                    state_n     = IDLE;
                    ptr_n       = next_owner;
                    grant_n     = '0;
                    grant_idx_n = '0;
                    busy_n      = 1'b0;
                    slice_cnt_n = '0;
                    preempt_n   = req[grant_idx];
                end else begin
                    slice_cnt_n = slice_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            preempt   <= 1'b0;
            slice_cnt <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grant     <= grant_n;
            grant_idx <= grant_idx_n;
            busy      <= busy_n;
            preempt   <= preempt_n;
            slice_cnt <= slice_cnt_n;
        end
    end

endmodule

// File: doc/rr_slice_arbiter.md
RR_SLICE_ARBITER -- requirements
Module: rr_slice_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters sharing one resource.
REQ-002 SHALL have parameter W, default 2, index width; W = ceil(log2(N)).
REQ-003 SHALL have parameter SLICE, default 8, maximum consecutive grant cycles per owner; SLICE >= 2.
REQ-004 SHALL have parameter SW, default 3, slice counter width; 2^SW >= SLICE.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port req  input  N  request vector, bit i = requester i; level-held while it wants the resource.
REQ-008 SHALL have port grant  output  N  registered one-hot grant; all-zero when idle.
REQ-009 SHALL have port grant_idx  output  W  registered index of current owner; 0 when idle.
REQ-010 SHALL have port busy  output  1  registered; high while any grant bit is high.
REQ-011 SHALL have port preempt  output  1  registered one-cycle pulse on slice-expiry revocation.
REQ-012 SHALL have port slice_cnt  output  SW  registered count of completed grant cycles for the current owner.

Function
REQ-013 SHALL implement two states: IDLE (grant=0) and GRANT (exactly one grant bit high).
REQ-014 SHALL hold an internal W-bit priority pointer ptr, reset to 0.
REQ-015 In IDLE with req != 0 at an edge: SHALL grant the first set bit of req searching ptr, ptr+1, ... modulo N; SHALL enter GRANT with slice_cnt=0. Latency: 1 edge from req sample to grant.
REQ-016 In IDLE with req == 0: SHALL remain in IDLE with all outputs held at reset values.
REQ-017 In GRANT, owner's req bit high, slice_cnt < SLICE-1: SHALL hold grant and increment slice_cnt by 1.
REQ-018 In GRANT, owner's req bit high, slice_cnt == SLICE-1: SHALL clear grant, set preempt=1 for one cycle, set ptr = owner+1 mod N, and enter IDLE. Grant is visible for exactly SLICE cycles.
REQ-019 In GRANT, owner's req bit low at an edge: SHALL clear grant, set ptr = owner+1 mod N, and enter IDLE without a preempt pulse (voluntary release).
REQ-020 Every GRANT->IDLE transition SHALL produce exactly one idle bubble cycle before any new grant.
REQ-021 Changes on non-owner req bits during GRANT SHALL NOT affect grant, slice_cnt, or ptr.
REQ-022 When release and slice expiry coincide, i.e. owner req drops when slice_cnt == SLICE-1, the release SHALL win: no preempt pulse.
REQ-023 Pointer wrap: owner N-1 SHALL set ptr to 0.
REQ-024 A preempted sole requester SHALL be re-granted after the bubble cycle.
REQ-025 grant SHALL never have more than one bit set; grant_idx SHALL always equal the index of the set grant bit.
REQ-026 slice_cnt SHALL read 0 in IDLE and SHALL never exceed SLICE-1.

Reset
REQ-027 rst high at an edge SHALL force: state IDLE, grant=0, grant_idx=0, busy=0, preempt=0, slice_cnt=0, ptr=0; rst SHALL take priority over all other conditions.
REQ-028 rst asserted mid-GRANT SHALL revoke the grant at that edge with no preempt pulse; arbitration SHALL resume on the first edge after rst deasserts.

Verification (N=4, SLICE=8)
REQ-029 Bench SHALL cover: IDLE, req=0100 -> after 1 edge grant=0100, grant_idx=2, busy=1, slice_cnt=0.
REQ-030 Bench SHALL cover: req=1111 held from reset -> grant 0001 for 8 cycles, preempt pulse, 1 bubble cycle, then 0010, 0100, 1000, 0001 in turn, 8 cycles each.
REQ-031 Bench SHALL cover: owner 1 drops req after 3 grant cycles, req=1101 -> grant=0 next edge with preempt=0, then grant=0100 (ptr=2).
REQ-032 Bench SHALL cover: owner 3 releases, req=0011 -> after bubble grant=0001 (pointer wrap).
REQ-033 Bench SHALL cover: rst pulsed while grant=0100, slice_cnt=5 -> all outputs 0 next edge; then req=1000 -> grant=1000 one edge after rst deasserts.
REQ-034 Bench SHALL cover: req=0001 continuous -> grant 8 cycles, preempt=1, 1 idle cycle, grant=0001 again with slice_cnt=0.
